cv32e40p_rf_write_arbiter: RTL and testbench

Shares the register file's two write ports (W1 = port A, W2 = port B) between the core's writeback sources.
- Requester 0 (EX/ALU writeback) owns port A and is never stalled.
- Requesters 1..NUM_REQ-1 (LSU, APU/FPU, ...) contend for port B through a round-robin arbiter with starvation protection.
- Resolves same-address collisions between the two ports and supports the synchronous setback clear.
- Sits between the writeback stage and the register file.

---
 rtl/cv32e40p_pkg.sv | 11 +
 rtl/cv32e40p_rr_arbiter.sv | 33 +++
 rtl/cv32e40p_rf_write_arbiter.sv | 78 +++++++
 tb/tb_cv32e40p_rf_write_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared constants and request type for the register file write arbiter.
package cv32e40p_pkg;
  localparam int RF_ADDR_W = 6;
  localparam int RF_DATA_W = 32;
  localparam int RF_MAX_WAIT = 7;
  localparam int RF_WAIT_W = $clog2(RF_MAX_WAIT + 1);
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wreq_t;
endpackage

// File: rtl/cv32e40p_rr_arbiter.sv
// cv32e40p_rr_arbiter: one-hot round-robin grant over requesters 1..N-1.
// A set prio bit overrides rotation; the lowest-index prioritised requester wins.
module cv32e40p_rr_arbiter #(
  parameter int N = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:1]  req,
  input  logic [N-1:1]  prio,
  input  logic [PW-1:0] ptr,
  output logic [N-1:1]  gnt
);
  logic hit;
  // three passes: promoted requesters, then ptr..N-1, then wrap back from 1
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = 1; i < N; i++)
      if (!hit && req[i] && prio[i]) begin
        gnt[i] = 1'b1;
        hit = 1'b1;
      end
    for (int i = 1; i < N; i++)
      if (!hit && req[i] && i >= int'(ptr)) begin
        gnt[i] = 1'b1;
        hit = 1'b1;
      end
    for (int i = 1; i < N; i++)
      if (!hit && req[i]) begin
        gnt[i] = 1'b1;
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/cv32e40p_rf_write_arbiter.sv
// cv32e40p_rf_write_arbiter: requester 0 owns RF port A; the rest share port B
// via round-robin with starvation promotion and same-address collision drop.
module cv32e40p_rf_write_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int MAX_WAIT = RF_MAX_WAIT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 setback_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
  output logic [ADDR_WIDTH-1:0]                waddr_a_o,
  output logic [DATA_WIDTH-1:0]                wdata_a_o,
  output logic                                 we_a_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  output logic                                 we_b_o,
  output logic                                 collision_o,
  output logic [NUM_REQ-1:0]                   starve_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [PW-1:0] rr_ptr, ptr_nxt;
  logic [NUM_REQ-1:1][WAIT_W-1:0] wait_cnt;
  logic [NUM_REQ-1:1] gnt;
  rf_wreq_t win;
  logic any_b, hit_a;
  cv32e40p_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (req_valid_i[NUM_REQ-1:1]),
    .prio (starve_o[NUM_REQ-1:1]),
    .ptr  (rr_ptr),
    .gnt  (gnt)
  );
  always_comb begin
    win = '0;
    ptr_nxt = rr_ptr;
    for (int i = 1; i < NUM_REQ; i++)
      if (gnt[i]) begin
        win.addr = req_addr_i[i];
        win.data = req_data_i[i];
        ptr_nxt = i == NUM_REQ - 1 ? PW'(1) : PW'(i + 1);
      end
  end
  always_comb begin
    starve_o = '0;
    for (int i = 1; i < NUM_REQ; i++)
      starve_o[i] = wait_cnt[i] == WAIT_W'(MAX_WAIT);
  end
  assign any_b = |gnt;
  assign hit_a = req_valid_i[0] && req_addr_i[0] != '0;
  assign req_ready_o = {gnt, 1'b1};
  assign waddr_a_o = req_valid_i[0] ? req_addr_i[0] : '0;
  assign wdata_a_o = req_valid_i[0] ? req_data_i[0] : '0;
  assign we_a_o = rst_n && hit_a;
  assign waddr_b_o = win.addr;
  assign wdata_b_o = win.data;
  // EX result is newer, so an equal-address port-B write is dropped but still handshaken
  assign collision_o = rst_n && any_b && hit_a && win.addr == req_addr_i[0];
  assign we_b_o = rst_n && any_b && win.addr != '0 && !collision_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= PW'(1);
      wait_cnt <= '0;
    end else if (setback_i) begin
      rr_ptr <= PW'(1);
      wait_cnt <= '0;
    end else begin
      rr_ptr <= ptr_nxt;
      for (int i = 1; i < NUM_REQ; i++)
        wait_cnt[i] <= req_valid_i[i] && !gnt[i] ? (starve_o[i] ? wait_cnt[i] : wait_cnt[i] + 1'b1) : '0;
    end
endmodule

// File: tb/tb_cv32e40p_rf_write_arbiter.sv
// tb_cv32e40p_rf_write_arbiter: directed vectors feed a scoreboard queue; a monitor
// pops one expected response per cycle and compares on the falling edge.
module tb_cv32e40p_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic setback_i = 1'b0;
  logic [2:0] req_valid_i = '0;
  logic [2:0] req_ready_o;
  logic [2:0][5:0] req_addr_i = '0;
  logic [2:0][31:0] req_data_i = '0;
  logic [5:0] waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic we_a_o, we_b_o, collision_o;
  logic [2:0] starve_o;
  typedef struct {
    string nm;
    logic [2:0] rdy;
    logic wea;
    logic [5:0] aa;
    logic [31:0] da;
    logic web;
    logic [5:0] ab;
    logic [31:0] db;
    logic col;
    logic [2:0] stv;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic rst_lvl = 1'b0;
  logic [5:0] ca[3] = '{default: '0};
  logic [31:0] cd[3] = '{default: '0};
  logic [2:0] pend = '0;
  cv32e40p_rf_write_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .setback_i   (setback_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .waddr_a_o   (waddr_a_o),
    .wdata_a_o   (wdata_a_o),
    .we_a_o      (we_a_o),
    .waddr_b_o   (waddr_b_o),
    .wdata_b_o   (wdata_b_o),
    .we_b_o      (we_b_o),
    .collision_o (collision_o),
    .starve_o    (starve_o)
  );
  always #5 clk = ~clk;
  // drive one cycle of stimulus and queue its hand-computed response (w = port-B winner, 0 = none)
  task automatic cyc(input string nm, input logic [2:0] v, input logic sb, input int w,
                     input logic web, input logic col, input logic [2:0] stv);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_lvl;
    setback_i = sb;
    req_valid_i = v;
    for (int i = 0; i < 3; i++) begin
      req_addr_i[i] = ca[i];
      req_data_i[i] = cd[i];
    end
    e.nm = nm;
    e.rdy = {w == 2, w == 1, 1'b1};
    e.wea = rst_lvl && v[0] && ca[0] != 6'd0;
    e.aa = v[0] ? ca[0] : 6'd0;
    e.da = v[0] ? cd[0] : 32'd0;
    e.web = web;
    e.ab = w != 0 ? ca[w] : 6'd0;
    e.db = w != 0 ? cd[w] : 32'd0;
    e.col = col;
    e.stv = stv;
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({req_ready_o, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o, collision_o, starve_o} !==
          {e.rdy, e.wea, e.aa, e.da, e.web, e.ab, e.db, e.col, e.stv}) begin
        fails++;
        $display("FAIL %s: got rdy=%b wea=%b aa=%0d da=%h web=%b ab=%0d db=%h col=%b stv=%b; want rdy=%b wea=%b aa=%0d da=%h web=%b ab=%0d db=%h col=%b stv=%b",
                 e.nm, req_ready_o, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o, collision_o, starve_o,
                 e.rdy, e.wea, e.aa, e.da, e.web, e.ab, e.db, e.col, e.stv);
      end
    end
  // a requester left waiting must still be valid in the following cycle
  always @(posedge clk) begin
    if (rst_n && (pend & ~req_valid_i) != 3'b000) begin
      fails++;
      $display("FAIL valid_drop: pending=%b valid=%b", pend, req_valid_i);
    end
    pend <= rst_n && !setback_i ? req_valid_i & ~req_ready_o : 3'b000;
  end
  initial begin
    cyc("reset", 3'b000, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    rst_lvl = 1'b1;
    ca[0] = 6'd5; cd[0] = 32'hDEAD_BEEF;
    cyc("t1_porta", 3'b001, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    ca[0] = 6'd0; cd[0] = 32'd0;
    ca[1] = 6'd10; cd[1] = 32'hA1A1_0001;
    ca[2] = 6'd20; cd[2] = 32'hA2A2_0002;
    cyc("t2_rr_g1a", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t2_rr_g2a", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("t2_rr_g1b", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t2_rr_g2b", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("t2_drain", 3'b010, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    ca[0] = 6'd7; cd[0] = 32'h0E0E_0007;
    ca[1] = 6'd7; cd[1] = 32'hB1B1_0007;
    cyc("t3_collide", 3'b011, 1'b0, 1, 1'b0, 1'b1, 3'b000);
    ca[0] = 6'd0; cd[0] = 32'd0;
    ca[2] = 6'd21; cd[2] = 32'hC2C2_0021;
    cyc("ptr_to_1", 3'b100, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("t3_idle", 3'b000, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    ca[1] = 6'd0; cd[1] = 32'h0000_1234;
    cyc("t5_zero_addr", 3'b010, 1'b0, 1, 1'b0, 1'b0, 3'b000);
    ca[1] = 6'd11; cd[1] = 32'hA3A3_0011;
    ca[2] = 6'd22; cd[2] = 32'hA4A4_0022;
    cyc("t5_ptr_is_2", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("t5_drain", 3'b010, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    ca[1] = 6'd12; cd[1] = 32'hA5A5_0012;
    ca[2] = 6'd23; cd[2] = 32'hA6A6_0023;
    force dut.rr_ptr = 2'd1;
    for (int i = 0; i < 7; i++) cyc("t4_deny", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t4_starve", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b100);
    for (int i = 0; i < 4; i++) cyc("t6_stall", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_setback", 3'b110, 1'b1, 1, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 7; i++) cyc("t6_recount", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_restarve", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b100);
    release dut.rr_ptr;
    cyc("t6_pre_g1", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_pre_g2", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("t6_pre_g1b", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    rst_lvl = 1'b0;
    cyc("t6_async_rst", 3'b110, 1'b0, 1, 1'b0, 1'b0, 3'b000);
    rst_lvl = 1'b1;
    cyc("t6_post_rst", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_post_g2", 3'b110, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("sb_pre", 3'b010, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_sb_ptr", 3'b010, 1'b1, 1, 1'b1, 1'b0, 3'b000);
    cyc("t6_sb_check", 3'b110, 1'b0, 1, 1'b1, 1'b0, 3'b000);
    cyc("drain", 3'b100, 1'b0, 2, 1'b1, 1'b0, 3'b000);
    cyc("final_idle", 3'b000, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
